// File: rtl/mem_hs_pkg.sv
// Shared definitions for the mem_hs scratch memory: FSM states, byte-lane
// width and the per-lane even-parity helper. Optional build macro used by
// the other files of this block: MEM_PARITY_EN.
package mem_hs_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int LANE_BITS = 8;

  // Even parity: the stored bit makes the total count of ones in lane+bit even.
  function automatic logic even_parity(input logic [LANE_BITS-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/mem_hs_if.sv
// Request/response bundle for mem_hs. The master drives requests and
// consumes responses; the slave is the memory. The err_inj signal only
// exists when MEM_PARITY_EN is defined.
interface mem_hs_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 7
);
  import mem_hs_pkg::*;

  localparam int LANES = WIDTH / LANE_BITS;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic [LANES-1:0]      req_be;
`ifdef MEM_PARITY_EN
  logic                  err_inj;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_err;

`ifdef MEM_PARITY_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, err_inj, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, err_inj, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`endif

endinterface

// File: rtl/mem_hs_array.sv
// Storage for mem_hs: byte-lane masked write port and a registered read port
// that only updates when a read is taken, so its output doubles as the held
// response data. With MEM_PARITY_EN each lane also keeps an even-parity bit
// that is checked against the registered read data.
module mem_hs_array
  import mem_hs_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/LANE_BITS-1:0] be,
`ifdef MEM_PARITY_EN
  input  logic                     inj,
`endif
  input  logic                     rd_en,
  input  logic                     rd_zero,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_perr
);

  localparam int LANES = WIDTH / LANE_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Lane-masked write into the word array; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][i*LANE_BITS +: LANE_BITS] <= wdata[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [LANES-1:0] par [DEPTH];
  logic [LANES-1:0] par_q;

  // Parity bits follow their lane; error injection flips lane 0's bit.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          par[addr][i] <= even_parity(wdata[i*LANE_BITS +: LANE_BITS]) ^ ((i == 0) && inj);
        end
      end
    end
  end

  // Read register: loads on a taken read, zero for out-of-range addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      par_q <= '0;
    end else if (rd_en) begin
      rd_q  <= rd_zero ? '0 : mem[addr];
      par_q <= rd_zero ? '0 : par[addr];
    end
  end

  // Any lane whose stored parity disagrees with its data flags an error.
  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (par_q[i] != even_parity(rd_q[i*LANE_BITS +: LANE_BITS])) begin
        rd_perr = 1'b1;
      end
    end
  end
`else
  // Read register: loads on a taken read, zero for out-of-range addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_zero ? '0 : mem[addr];
    end
  end

  assign rd_perr = 1'b0;
`endif

  assign rd_data = rd_q;

endmodule

// File: rtl/mem_hs.sv
// mem_hs: single-port word memory with valid/ready requests, a registered
// back-pressurable read response, byte-lane writes, a zeroing sweep after
// reset or on clr, and out-of-range error reporting. Optional macro
// MEM_PARITY_EN adds per-lane parity with an err_inj test input.
module mem_hs
  import mem_hs_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  output logic     busy,
  mem_hs_if.slave  bus
);

  localparam int                    LANES     = WIDTH / LANE_BITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] count, count_d;
  logic                  clr_pending, clr_pending_d;
  logic                  rsp_valid, rsp_valid_d;
  logic                  rsp_oor, rsp_oor_d;

  logic                  in_range;
  logic                  take;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [LANES-1:0]      mem_be;
  logic                  rd_en;
  logic                  rd_zero;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_perr;
`ifdef MEM_PARITY_EN
  logic                  mem_inj;
`endif

  assign in_range      = {1'b0, bus.req_addr} < DEPTH_W;
  assign bus.req_ready = (state == ST_RUN) && !clr_pending && (!rsp_valid || bus.rsp_ready);
  assign take          = bus.req_valid && bus.req_ready;
  assign busy          = (state == ST_INIT) || clr_pending;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rd_data;
  assign bus.rsp_err   = rsp_oor | rd_perr;

  // State, sweep counter, pending clear and response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_INIT;
      count       <= '0;
      clr_pending <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_oor     <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      clr_pending <= clr_pending_d;
      rsp_valid   <= rsp_valid_d;
      rsp_oor     <= rsp_oor_d;
    end
  end

  // Next state and array control: sweep writes zeros, run mode serves requests.
  always_comb begin
    state_d       = state;
    count_d       = count;
    clr_pending_d = clr_pending;
    rsp_valid_d   = rsp_valid;
    rsp_oor_d     = rsp_oor;
    mem_we        = 1'b0;
    mem_addr      = bus.req_addr;
    mem_wdata     = bus.req_wdata;
    mem_be        = bus.req_be;
    rd_en         = 1'b0;
    rd_zero       = 1'b0;
`ifdef MEM_PARITY_EN
    mem_inj       = 1'b0;
`endif

    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = count;
        mem_wdata = '0;
        mem_be    = '1;
        if (count == LAST_ADDR) begin
          state_d = ST_RUN;
          count_d = '0;
        end else begin
          count_d = count + 1'b1;
        end
      end

      ST_RUN: begin
        if (rsp_valid && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
        if (take) begin
          if (bus.req_we) begin
            mem_we = in_range;
`ifdef MEM_PARITY_EN
            mem_inj = bus.err_inj;
`endif
          end else begin
            rd_en       = 1'b1;
            rd_zero     = !in_range;
            rsp_valid_d = 1'b1;
            rsp_oor_d   = !in_range;
          end
        end
        if (clr) begin
          clr_pending_d = 1'b1;
        end
        // A pending clear waits until no response is outstanding after this edge.
        if (clr_pending && (!rsp_valid || bus.rsp_ready)) begin
          state_d       = ST_INIT;
          count_d       = '0;
          clr_pending_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
        count_d = '0;
      end
    endcase
  end

  mem_hs_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .be      (mem_be),
`ifdef MEM_PARITY_EN
    .inj     (mem_inj),
`endif
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_data (rd_data),
    .rd_perr (rd_perr)
  );

endmodule
